fft_sample_framer: RTL and testbench

FFT_SAMPLE_FRAMER -- requirements
Module: fft_sample_framer

---
 rtl/fft_pkg.sv | 23 ++
 rtl/fft_sample_framer_adc_to_complex.sv | 23 ++
 rtl/fft_sample_framer.sv | 104 ++++++++++
 tb/tb_fft_sample_framer.sv | 272 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/fft_pkg.sv
// Shared sizes, complex word layout and FSM state encodings
// for the FFT sample framer.
package fft_pkg;

  localparam int N      = 16;
  localparam int HALF_W = 18;

  typedef struct packed {
    logic signed [HALF_W-1:0] re;
    logic signed [HALF_W-1:0] im;
  } complex_t;

  typedef enum logic {
    WR_FILL,
    WR_FULL
  } wr_state_t;

  typedef enum logic {
    TRK_IDLE,
    TRK_RUN
  } trk_state_t;

endpackage

// File: rtl/fft_sample_framer_adc_to_complex.sv
// Offset-binary ADC code to signed complex word {real, imag},
// imag forced to zero.
module adc_to_complex #(
  parameter int SAMPLE_W = 12,
  parameter int HALF_W   = 18
) (
  input  logic [SAMPLE_W-1:0] sample,
  output logic [2*HALF_W-1:0] cplx
);

  logic [SAMPLE_W-1:0] centered;

  // Subtracting mid-scale is just an MSB flip.
  assign centered = {~sample[SAMPLE_W-1],
                     sample[SAMPLE_W-2:0]};

  assign cplx = {
    {(HALF_W-SAMPLE_W){centered[SAMPLE_W-1]}},
    centered,
    {HALF_W{1'b0}}
  };

endmodule

// File: rtl/fft_sample_framer.sv
// Ping-pong sample framer feeding an FFT core.
// Define FRAMER_DROP_CNT_EN to build the dropped-sample counter.
module fft_sample_framer #(
  parameter int N        = fft_pkg::N,
  parameter int SAMPLE_W = 12,
  parameter int HALF_W   = fft_pkg::HALF_W
) (
  input  logic                           clock,
  input  logic                           reset,
  input  logic                           sample_valid,
  input  logic [SAMPLE_W-1:0]            sample_in,
  input  logic                           fft_done,
  output logic                           fft_start,
  output logic [N-1:0][2*HALF_W-1:0]     frame,
  output logic                           busy,
  output logic [7:0]                     drop_count
);

  import fft_pkg::*;

  localparam int IW = $clog2(N);

  typedef logic [N-1:0][2*HALF_W-1:0] bank_t;

  wr_state_t           wr_state, wr_next;
  trk_state_t          trk_state, trk_next;
  logic [IW-1:0]       wr_idx;
  logic                wr_sel;
  bank_t               banks [2];
  logic [2*HALF_W-1:0] cplx;
  logic                wr_en;
  logic                swap;

  adc_to_complex #(
    .SAMPLE_W(SAMPLE_W),
    .HALF_W  (HALF_W)
  ) u_conv (
    .sample(sample_in),
    .cplx  (cplx)
  );

  always_comb begin
    swap     = (wr_state == WR_FULL) &&
               (trk_state == TRK_IDLE);
    wr_en    = (wr_state == WR_FILL) && sample_valid;
    wr_next  = wr_state;
    trk_next = trk_state;
    unique case (wr_state)
      WR_FILL:
        if (wr_en && wr_idx == IW'(N-1))
          wr_next = WR_FULL;
      WR_FULL:
        if (swap) wr_next = WR_FILL;
    endcase
    // The start cycle masks a done still held from the last run.
    unique case (trk_state)
      TRK_IDLE:
        if (swap) trk_next = TRK_RUN;
      TRK_RUN:
        if (fft_done && !fft_start)
          trk_next = TRK_IDLE;
    endcase
  end

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      wr_state  <= WR_FILL;
      trk_state <= TRK_IDLE;
      wr_idx    <= '0;
      wr_sel    <= 1'b0;
      fft_start <= 1'b0;
      banks     <= '{default: '0};
    end else begin
      wr_state  <= wr_next;
      trk_state <= trk_next;
      fft_start <= swap;
      if (swap) wr_sel <= ~wr_sel;
      if (wr_en) begin
        banks[wr_sel][wr_idx] <= cplx;
        wr_idx <= wr_idx + 1'b1;
      end
    end
  end

  assign frame = banks[~wr_sel];
  assign busy  = (trk_state == TRK_RUN);

`ifdef FRAMER_DROP_CNT_EN
  logic [7:0] drop_cnt;

  always_ff @(posedge clock or negedge reset) begin
    if (!reset)
      drop_cnt <= '0;
    else if (sample_valid && wr_state == WR_FULL &&
             drop_cnt != 8'hFF)
      drop_cnt <= drop_cnt + 8'd1;
  end

  assign drop_count = drop_cnt;
`else
  assign drop_count = '0;
`endif

endmodule

// File: tb/tb_fft_sample_framer.sv
// Self-checking bench for fft_sample_framer: conversion table,
// ping-pong handoff, drops, done masking and reset recovery.
module tb_fft_sample_framer;

  localparam int N  = 16;
  localparam int SW = 12;
  localparam int HW = 18;

  logic                      clock;
  logic                      reset;
  logic                      sample_valid;
  logic [SW-1:0]             sample_in;
  logic                      fft_done;
  logic                      fft_start;
  logic [N-1:0][2*HW-1:0]    frame;
  logic                      busy;
  logic [7:0]                drop_count;

  fft_sample_framer #(
    .N(N), .SAMPLE_W(SW), .HALF_W(HW)
  ) dut (
    .clock       (clock),
    .reset       (reset),
    .sample_valid(sample_valid),
    .sample_in   (sample_in),
    .fft_done    (fft_done),
    .fft_start   (fft_start),
    .frame       (frame),
    .busy        (busy),
    .drop_count  (drop_count)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  typedef struct {
    logic [SW-1:0]   code;
    logic [2*HW-1:0] exp;
  } vec_t;

  vec_t              tbl [16];
  logic [2*HW-1:0]   sb [$];
  int                checks;
  int                failures;
  int                exp_drop;
  int                starts;

  always @(posedge clock)
    if (fft_start) starts <= starts + 1;

  function automatic logic [2*HW-1:0] model(
    input logic [SW-1:0] code);
    logic signed [HW-1:0] r;
    r = $signed({6'd0, code}) - 18'sd2048;
    return {r, 18'd0};
  endfunction

  task automatic check(input string name,
                       input logic [63:0] act,
                       input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%0h required=%0h",
               name, act, exp);
    end
  endtask

  task automatic send(input logic [SW-1:0] code,
                      input bit acc,
                      input logic [2*HW-1:0] exp);
    sample_valid = 1'b1;
    sample_in    = code;
    if (acc) sb.push_back(exp);
`ifdef FRAMER_DROP_CNT_EN
    else if (exp_drop < 255) exp_drop++;
`endif
    @(posedge clock);
    #1;
    sample_valid = 1'b0;
  endtask

  task automatic send_rand_frame();
    logic [SW-1:0] c;
    for (int i = 0; i < N; i++) begin
      c = SW'($urandom_range(4095, 0));
      send(c, 1'b1, model(c));
    end
  endtask

  task automatic wait_start(input int budget,
                            output int cyc);
    bit seen;
    seen = 1'b0;
    cyc  = 0;
    for (int k = 1; k <= budget && !seen; k++) begin
      @(negedge clock);
      if (fft_start) begin
        seen = 1'b1;
        cyc  = k;
      end
    end
    check("start_seen", 64'(seen), 64'd1);
  endtask

  task automatic check_frame(input string tag);
    logic [2*HW-1:0] e;
    for (int i = 0; i < N; i++) begin
      if (sb.size() == 0) begin
        checks++;
        failures++;
        $display("FAIL %s_sb_empty actual=0 required=%0d",
                 tag, N - i);
        break;
      end
      e = sb.pop_front();
      check($sformatf("%s[%0d]", tag, i),
            64'(frame[i]), 64'(e));
    end
  endtask

  task automatic pulse_done();
    fft_done = 1'b1;
    @(posedge clock);
    #1;
    fft_done = 1'b0;
  endtask

  initial begin
    #400000;
    $display("FAIL watchdog actual=timeout required=finish");
    $fatal(1);
  end

  initial begin
    int cyc;
    int s0;
    logic [SW-1:0] c;
    checks   = 0;
    failures = 0;
    exp_drop = 0;
    starts   = 0;

    tbl[0]  = '{12'd4095, {18'h007FF, 18'd0}};
    tbl[1]  = '{12'd2048, {18'h00000, 18'd0}};
    tbl[2]  = '{12'd0,    {18'h3F800, 18'd0}};
    tbl[3]  = '{12'd1,    {18'h3F801, 18'd0}};
    tbl[4]  = '{12'd2047, {18'h3FFFF, 18'd0}};
    tbl[5]  = '{12'd2049, {18'h00001, 18'd0}};
    tbl[6]  = '{12'd4094, {18'h007FE, 18'd0}};
    tbl[7]  = '{12'd1024, {18'h3FC00, 18'd0}};
    tbl[8]  = '{12'd3072, {18'h00400, 18'd0}};
    tbl[9]  = '{12'd100,  {18'h3F864, 18'd0}};
    tbl[10] = '{12'd4000, {18'h007A0, 18'd0}};
    tbl[11] = '{12'd2000, {18'h3FFD0, 18'd0}};
    tbl[12] = '{12'd2100, {18'h00034, 18'd0}};
    tbl[13] = '{12'd512,  {18'h3FA00, 18'd0}};
    tbl[14] = '{12'd3584, {18'h00600, 18'd0}};
    tbl[15] = '{12'd2,    {18'h3F802, 18'd0}};

    reset        = 1'b0;
    sample_valid = 1'b0;
    sample_in    = '0;
    fft_done     = 1'b0;
    repeat (3) @(posedge clock);
    @(negedge clock);
    check("rst_start", 64'(fft_start), 64'd0);
    check("rst_busy",  64'(busy),      64'd0);
    check("rst_drop",  64'(drop_count), 64'd0);
    check("rst_frame", 64'(|frame),    64'd0);
    @(posedge clock);
    #1;
    reset = 1'b1;
    repeat (2) @(posedge clock);
    #1;

    // Frame A: codes 0..15, FFT idle.
    for (int i = 0; i < N; i++)
      send(SW'(i), 1'b1, model(SW'(i)));
    wait_start(8, cyc);
    check("latency_a", 64'(cyc), 64'd2);
    check_frame("frame_a");
    check("busy_a", 64'(busy), 64'd1);
    @(negedge clock);
    check("pulse_a", 64'(fft_start), 64'd0);
    s0 = starts;

    // Frame B from the table while busy, then three drops.
    for (int i = 0; i < N; i++)
      send(tbl[i].code, 1'b1, tbl[i].exp);
    for (int i = 0; i < 3; i++)
      send(12'd77, 1'b0, '0);
    repeat (4) @(negedge clock);
    check("drop_b", 64'(drop_count), 64'(exp_drop));
    check("no_start_b", 64'(starts), 64'(s0));
    check("busy_b", 64'(busy), 64'd1);
    check("hold_a15", 64'(frame[15]), 64'(model(12'd15)));
    pulse_done();
    wait_start(6, cyc);
    check_frame("frame_b");
    @(negedge clock);
    check("pulse_b", 64'(fft_start), 64'd0);

    // Frame C with done held high, plus a strobe on the swap edge.
    fft_done = 1'b1;
    send_rand_frame();
    send(12'd999, 1'b0, '0);
    wait_start(4, cyc);
    check("busy_c0", 64'(busy), 64'd1);
    @(negedge clock);
    check("busy_c1", 64'(busy), 64'd1);
    @(negedge clock);
    check("busy_c2", 64'(busy), 64'd0);
    fft_done = 1'b0;
    check_frame("frame_c");
    check("drop_c", 64'(drop_count), 64'(exp_drop));

    // Frame C2 shows the swap-edge strobe was not stored.
    send_rand_frame();
    wait_start(8, cyc);
    check("latency_c2", 64'(cyc), 64'd2);
    check_frame("frame_c2");

    // Reset mid-frame (and mid-FFT).
    for (int i = 0; i < 7; i++)
      send(12'd3333, 1'b1, '0);
    reset = 1'b0;
    #2;
    check("mid_rst_start", 64'(fft_start), 64'd0);
    check("mid_rst_busy",  64'(busy),      64'd0);
    check("mid_rst_drop",  64'(drop_count), 64'd0);
    check("mid_rst_frame", 64'(|frame),    64'd0);
    sb.delete();
    exp_drop = 0;
    @(posedge clock);
    #1;
    reset = 1'b1;
    @(posedge clock);
    #1;
    s0 = starts;
    send(12'd3000, 1'b1, {18'h003B8, 18'd0});
    for (int i = 1; i < N; i++) begin
      c = SW'($urandom_range(4095, 0));
      send(c, 1'b1, model(c));
    end
    wait_start(8, cyc);
    check("latency_d", 64'(cyc), 64'd2);
    check_frame("frame_d");
    @(negedge clock);
    check("one_start_d", 64'(starts), 64'(s0 + 1));

    // Saturation: fill, then 300 strobes while full.
    send_rand_frame();
    for (int i = 0; i < 300; i++)
      send(12'd5, 1'b0, '0);
    @(negedge clock);
`ifdef FRAMER_DROP_CNT_EN
    check("drop_sat", 64'(drop_count), 64'd255);
`else
    check("drop_off", 64'(drop_count), 64'd0);
`endif
    check("drop_model", 64'(drop_count), 64'(exp_drop));
    pulse_done();
    wait_start(6, cyc);
    check_frame("frame_e");

    $display("TB_RESULT checks=%0d failures=%0d",
             checks, failures);
    $finish;
  end

endmodule
